// File: rtl/mem_load_pipeline.sv
// rtl/mem_load_pipeline.sv - three-stage load pipeline: request, memory read, response/register write
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data     data memory fill port (never stalled)
//   req_valid/req_ready         load request handshake; req_addr, req_rd carried with it
//   rsp_valid/rsp_ready         load response handshake; rsp_data, rsp_rd, rsp_addr carried with it
//   rf_rs, rf_data              combinational register-bank peek
//   busy                        any pipeline stage holds a load
module mem_load_pipeline #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [RW-1:0] req_rd,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [RW-1:0] rsp_rd,
  output logic [AW-1:0] rsp_addr,
  input  logic [RW-1:0] rf_rs,
  output logic [DW-1:0] rf_data,
  output logic          busy
);

  localparam int DEPTH = 1 << AW;
  localparam int NREG  = 1 << RW;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] regbank [NREG];

  // Stage state: S1 = request latch, S2 = read data, S3 = response register
  logic          v1, v2, v3;
  logic [AW-1:0] a1, a2;
  logic [RW-1:0] rd1, rd2;
  logic [DW-1:0] d2;

  logic          stall;
  logic [DW-1:0] rd_word;

  // A waiting response freezes the whole pipe, bubbles included.
  assign stall     = v3 & ~rsp_ready;
  assign req_ready = ~stall;
  assign rsp_valid = v3;
  assign busy      = v1 | v2 | v3;
  assign rf_data   = regbank[rf_rs];

  // Write-first: a fill landing on the address S2 is reading this edge is forwarded.
  assign rd_word = (wr_en && (wr_addr == a1)) ? wr_data : mem[a1];

  // Data memory has no reset; the fill port ignores pipeline stalls.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      rsp_data <= '0;
      rsp_rd   <= '0;
      rsp_addr <= '0;
      for (int i = 0; i < NREG; i++) begin
        regbank[i] <= '0;
      end
    end else if (!stall) begin
      v1 <= req_valid;
      if (req_valid) begin
        a1  <= req_addr;
        rd1 <= req_rd;
      end

      v2 <= v1;
      if (v1) begin
        a2  <= a1;
        rd2 <= rd1;
        d2  <= rd_word;
      end

      // Entry into S3 is the single point where a load updates the register bank.
      v3 <= v2;
      if (v2) begin
        rsp_data     <= d2;
        rsp_rd       <= rd2;
        rsp_addr     <= a2;
        regbank[rd2] <= d2;
      end
    end
  end

endmodule

// File: tb/tb_mem_load_pipeline.sv
// tb/tb_mem_load_pipeline.sv - self-checking bench for mem_load_pipeline
module tb_mem_load_pipeline;

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  rd;
    logic [15:0] data;
  } ld_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [3:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_rd;
  logic [7:0]  rsp_addr;
  logic [3:0]  rf_rs;
  logic [15:0] rf_data;
  logic        busy;

  mem_load_pipeline #(.AW(8), .DW(16), .RW(4)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_addr(rsp_addr),
    .rf_rs(rf_rs), .rf_data(rf_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_rsp = 0;
  int          n0, k, stall_left;
  logic [15:0] mmem [256];
  logic [15:0] rf_m [16];
  ld_t         q[$];
  ld_t         tv [5];
  ld_t         tmp;
  bit          manual = 1'b0;
  bit          acc = 1'b0;
  bit          held = 1'b0;
  logic [15:0] hold_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One clock: observe handshakes at the negedge against the model, then advance.
  task automatic cycle();
    @(negedge clk);
    acc = 1'b0;
    if (!rst) begin
      if (wr_en) mmem[wr_addr] = wr_data;
      acc = req_valid && req_ready;
      chk("req_ready_rule", 32'(req_ready), 32'(!(rsp_valid && !rsp_ready)));
      if (acc && !manual) begin
        tmp.addr = req_addr;
        tmp.rd   = req_rd;
        tmp.data = mmem[req_addr];
        q.push_back(tmp);
      end
      if (held) begin
        chk("hold_valid", 32'(rsp_valid), 32'(1));
        chk("hold_data", 32'(rsp_data), 32'(hold_data));
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("rsp_extra", 32'(rsp_valid), 32'(0));
        end else begin
          chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
          chk("rsp_rd", 32'(rsp_rd), 32'(q[0].rd));
          chk("rsp_addr", 32'(rsp_addr), 32'(q[0].addr));
          rf_rs = q[0].rd;
          #1;
          chk("rf_at_s3", 32'(rf_data), 32'(q[0].data));
          if (rsp_ready) begin
            rf_m[q[0].rd] = q[0].data;
            void'(q.pop_front());
            n_rsp++;
          end
        end
      end
      held      = rsp_valid && !rsp_ready;
      hold_data = rsp_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    wr_en     = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && (busy || q.size() != 0); c++) cycle();
    chk("drain_queue", 32'(q.size()), 32'(0));
    chk("drain_busy", 32'(busy), 32'(0));
  endtask

  task automatic check_rf_all(input string nm);
    for (int i = 0; i < 16; i++) begin
      rf_rs = 4'(i);
      #1;
      chk(nm, 32'(rf_data), 32'(rf_m[i]));
    end
  endtask

  task automatic write_mem(input logic [7:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0] = '{8'h10, 4'd3, 16'hBEEF};
    tv[1] = '{8'h00, 4'd0, 16'h1111};
    tv[2] = '{8'h01, 4'd1, 16'h2222};
    tv[3] = '{8'h02, 4'd2, 16'h3333};
    tv[4] = '{8'h03, 4'd3, 16'h4444};
    foreach (rf_m[i]) rf_m[i] = 16'h0;
    foreach (mmem[i]) mmem[i] = 16'h0;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_addr = '0; req_rd = '0; rsp_ready = 1'b1; rf_rs = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_req_ready", 32'(req_ready), 32'(1));
    chk("reset_rsp_data", 32'(rsp_data), 32'(0));
    chk("reset_rsp_rd", 32'(rsp_rd), 32'(0));
    chk("reset_rsp_addr", 32'(rsp_addr), 32'(0));
    check_rf_all("reset_rf");

    // Table fill
    for (int i = 0; i < 5; i++) write_mem(tv[i].addr, tv[i].data);

    // Fill then load: latency of three edges
    req_valid = 1'b1; req_addr = tv[0].addr; req_rd = tv[0].rd;
    cycle();
    req_valid = 1'b0;
    chk("lat_edge1", 32'(rsp_valid), 32'(0));
    cycle();
    chk("lat_edge2", 32'(rsp_valid), 32'(0));
    cycle();
    chk("lat_edge3", 32'(rsp_valid), 32'(1));
    cycle();
    rf_rs = tv[0].rd; #1;
    chk("fill_load_rf", 32'(rf_data), 32'(tv[0].data));
    drain();

    // Streaming from the table
    for (int j = 0; j < 7; j++) begin
      req_valid = (j < 4);
      if (j < 4) begin
        req_addr = tv[j+1].addr; req_rd = tv[j+1].rd;
        chk("stream_req_ready", 32'(req_ready), 32'(1));
      end
      cycle();
      chk("stream_rsp_valid", 32'(rsp_valid), 32'(j >= 2 && j <= 5));
    end
    drain();

    // Backpressure: 5 stalled cycles after the first response
    n0 = n_rsp; k = 0; stall_left = -1;
    for (int c = 0; c < 40 && (k < 4 || busy); c++) begin
      req_valid = (k < 4);
      req_addr  = 8'(k);
      req_rd    = 4'(8 + k);
      rsp_ready = !(stall_left > 0);
      cycle();
      if (acc) k++;
      if (stall_left > 0) begin
        stall_left--;
        chk("bp_hold_1111", 32'(rsp_data), 32'(tv[1].data));
      end
      if (stall_left < 0 && rsp_valid) stall_left = 5;
    end
    chk("bp_issued", 32'(k), 32'(4));
    chk("bp_responses", 32'(n_rsp - n0), 32'(4));
    drain();
    for (int i = 0; i < 4; i++) begin
      rf_rs = 4'(8 + i); #1;
      chk("bp_rf", 32'(rf_data), 32'(tv[i+1].data));
    end

    // Collision: write lands on the edge the load reads in S2
    write_mem(8'h20, 16'h0001);
    manual = 1'b1;
    tmp = '{8'h20, 4'd5, 16'hCAFE}; q.push_back(tmp);
    req_valid = 1'b1; req_addr = 8'h20; req_rd = 4'd5;
    cycle();
    req_valid = 1'b0;
    write_mem(8'h20, 16'hCAFE);
    drain();
    // Same write one edge later: load already past S2
    write_mem(8'h20, 16'h0001);
    tmp = '{8'h20, 4'd6, 16'h0001}; q.push_back(tmp);
    req_valid = 1'b1; req_addr = 8'h20; req_rd = 4'd6;
    cycle();
    req_valid = 1'b0;
    cycle();
    write_mem(8'h20, 16'hCAFE);
    drain();
    manual = 1'b0;

    // Same-rd ordering
    write_mem(8'h30, 16'hAAAA);
    write_mem(8'h31, 16'h5555);
    req_valid = 1'b1; req_addr = 8'h30; req_rd = 4'd7;
    cycle();
    req_addr = 8'h31;
    cycle();
    drain();
    rf_rs = 4'd7; #1;
    chk("same_rd_last_wins", 32'(rf_data), 32'(16'h5555));

    // Reset with three loads in flight
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 8'(i); req_rd = 4'(i + 1);
      cycle();
    end
    req_valid = 1'b0;
    chk("inflight_busy", 32'(busy), 32'(1));
    rst = 1'b1; rsp_ready = 1'b0;
    cycle();
    rst = 1'b0;
    q.delete(); held = 1'b0;
    foreach (rf_m[i]) rf_m[i] = 16'h0;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_req_ready", 32'(req_ready), 32'(1));
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'(0));
    end
    check_rf_all("mid_rst_rf");

    // Randomized: loads from the lower half, fills to the upper half
    for (int a = 0; a < 128; a++) write_mem(8'(a), 16'($urandom));
    req_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = 8'($urandom_range(128, 255));
      wr_data = 16'($urandom);
      if (!req_valid || acc) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_addr  = 8'($urandom_range(0, 127));
        req_rd    = 4'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();
    check_rf_all("random_rf");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
